// File: rtl/fifo_loader.sv
// Write-side feeder for the dual-pop weight/input FIFO: streams Length words from a
// 1-cycle-latency SRAM into the FIFO, with a one-entry skid absorbing the read in flight.
module fifo_loader #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned LenWidth  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic [AddrWidth-1:0] BaseAddr,
  input  logic [LenWidth-1:0]  Length,
  output logic                 MemRe,
  output logic [AddrWidth-1:0] MemAddr,
  input  logic [DataWidth-1:0] MemData,
  input  logic                 Full,
  output logic                 Push,
  output logic [DataWidth-1:0] DataIn,
  output logic                 Busy,
  output logic                 Done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic [LenWidth-1:0]    issue_cnt_q;
  logic [LenWidth-1:0]    push_cnt_q;
  logic                   in_flight_q;
  logic                   skid_valid_q;
  logic [DataWidth-1:0]   skid_q;

  assign MemAddr = addr_q;
  assign Busy    = (state_q != ST_IDLE);
  assign Done    = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    MemRe   = 1'b0;
    Push    = 1'b0;
    DataIn  = skid_q;

    if (state_q == ST_FETCH) begin
      MemRe = (issue_cnt_q != '0) && !skid_valid_q && !(in_flight_q && Full);
    end

    // The skid always holds the older word, so it drains ahead of returning data.
    if (!Full) begin
      if (skid_valid_q) begin
        Push   = 1'b1;
        DataIn = skid_q;
      end else if (in_flight_q) begin
        Push   = 1'b1;
        DataIn = MemData;
      end
    end

    // Transitions look at the post-edge counts so Done follows the last push directly.
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = (Length == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if ((issue_cnt_q == '0) || (MemRe && (issue_cnt_q == LenWidth'(1)))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (((push_cnt_q == '0) && !in_flight_q && !skid_valid_q) ||
            (Push && (push_cnt_q == LenWidth'(1)))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      issue_cnt_q <= '0;
      push_cnt_q  <= '0;
      in_flight_q <= 1'b0;
    end else begin
      in_flight_q <= MemRe;
      if ((state_q == ST_IDLE) && Start) begin
        addr_q      <= BaseAddr;
        issue_cnt_q <= Length;
        push_cnt_q  <= Length;
      end else begin
        if (MemRe) begin
          addr_q      <= addr_q + AddrWidth'(1);
          issue_cnt_q <= issue_cnt_q - LenWidth'(1);
        end
        if (Push) begin
          push_cnt_q <= push_cnt_q - LenWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (skid_valid_q) begin
      if (!Full) begin
        if (in_flight_q) begin
          skid_q <= MemData;
        end else begin
          skid_valid_q <= 1'b0;
        end
      end
    end else if (in_flight_q && Full) begin
      skid_q       <= MemData;
      skid_valid_q <= 1'b1;
    end
  end

endmodule
